uart_time_transmitter: RTL and testbench
========================================

UART_TIME_TRANSMITTER -- requirements
Module: uart_time_transmitter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter BAUD_DIV, default CLK_FREQ/BAUD (integer, truncated; 5208 at defaults), clock cycles per bit.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to transmit one time report.
REQ-007 SHALL have port min2, input, 3, minutes tens digit.
REQ-008 SHALL have port min1, input, 4, minutes ones digit.
REQ-009 SHALL have port sec2, input, 3, seconds tens digit.
REQ-010 SHALL have port sec1, input, 4, seconds ones digit.
REQ-011 SHALL have port TxD, output, 1, serial line, 8N1, idle high.
REQ-012 SHALL have port busy, output, 1, high while a report is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at report completion.

Function
REQ-014 SHALL accept start only in IDLE on a rising clk edge; start while busy is ignored, not queued.
REQ-015 SHALL latch min2, min1, sec2, sec1 on the accepting edge; later input changes do not affect the report in flight.
REQ-016 SHALL transmit 7 characters in order: min2, min1, ':' (0x3A), sec2, sec1, CR (0x0D), LF (0x0A).
REQ-017 SHALL encode digit value d in 0..9 as 0x30+d; any digit value above 9 SHALL be sent as '?' (0x3F).
REQ-018 SHALL frame each character as start bit 0, 8 data bits LSB first, one stop bit 1; each bit held exactly BAUD_DIV cycles.
REQ-019 SHALL drive start bit of character 1 starting the cycle after acceptance; busy rises in that same cycle.
REQ-020 SHALL send characters back-to-back: next start bit begins the cycle after the previous stop bit's BAUD_DIV cycles, no idle gap.
REQ-021 SHALL use states IDLE -> START_BIT -> DATA_BITS (8 bits) -> STOP_BIT -> (START_BIT of next char, or DONE after char 7) -> IDLE.
REQ-022 SHALL, in DONE (one cycle), assert done=1, busy=0, TxD=1; a start in that cycle is ignored.
REQ-023 SHALL take exactly 70*BAUD_DIV+1 cycles from the accepting edge to the done pulse.
REQ-024 SHALL restart the baud counter at 0 on every bit boundary; counter width ceil(log2(BAUD_DIV)), no wrap-around drift.
REQ-025 SHALL hold TxD=1 at all times in IDLE and DONE.

Reset
REQ-026 SHALL, on reset assertion at any time including mid-character, immediately force TxD=1, busy=0, done=0, state IDLE, counters and character index 0.
REQ-027 SHALL accept a new start on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place in shared package uart_pkg: default CLK_FREQ, default BAUD, ASCII constants (zero 0x30, colon 0x3A, CR 0x0D, LF 0x0A, question 0x3F), state enumeration.
REQ-029 SHALL use one sub-module uart_tx_byte (serializer with load/ready handshake plus baud counter); uart_time_transmitter sequences the 7 characters into it.

Verification
REQ-030 SHALL test BAUD_DIV=16: min2=1,min1=2,sec2=3,sec1=4, start pulse -> decoded bytes 31 32 3A 33 34 0D 0A, done exactly 1121 cycles after accepting edge.
REQ-031 SHALL test start pulses at cycles 5 and 300 of a report -> one report only, no corruption, busy continuous.
REQ-032 SHALL test inputs changed to 5,9,5,9 mid-report -> bytes remain 31 32 3A 33 34 0D 0A.
REQ-033 SHALL test min1=12 (illegal), others 0 -> bytes 30 3F 3A 30 30 0D 0A.
REQ-034 SHALL test reset pulse during data bit 3 of char 2 -> TxD=1 and busy=0 immediately; new start then yields full correct report.
REQ-035 SHALL test every bit width measured on TxD -> exactly 16 cycles, idle line high between reports.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults, ASCII constants and state encoding for the time transmitter
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT     = 9600;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_COLON    = 8'h3A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_QUESTION = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } state_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QUESTION : (ASCII_ZERO + {4'd0, d});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with baud counter and load/ready handshake
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int                CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  // Ready on the last stop-bit cycle lets the next byte start with no idle gap.
  assign ready_o = (state_q == IDLE) || ((state_q == STOP_BIT) && bit_end);
  assign txd_o   = txd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else if (ready_o) begin
      cnt_q <= '0;
      bit_q <= '0;
      if (load_i) begin
        state_q <= START_BIT;
        shift_q <= data_i;
        txd_q   <= 1'b0;
      end else begin
        state_q <= IDLE;
        txd_q   <= 1'b1;
      end
    end else if (!bit_end) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
      case (state_q)
        START_BIT: begin
          state_q <= DATA_BITS;
          txd_q   <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
        end
        DATA_BITS: begin
          if (bit_q == 3'd7) begin
            state_q <= STOP_BIT;
            txd_q   <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_time_transmitter.sv
// rtl/uart_time_transmitter.sv - sends "MM:SS\r\n" as seven back-to-back 8N1 characters per start
module uart_time_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int BAUD     = BAUD_DEFAULT,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] min2,
  input  logic [3:0] min1,
  input  logic [2:0] sec2,
  input  logic [3:0] sec1,
  output logic       TxD,
  output logic       busy,
  output logic       done
);

  // START_BIT here spans the whole character stream; per-bit phases live in uart_tx_byte.
  state_t     state_q;
  logic [2:0] char_idx_q;
  logic [2:0] min2_q, sec2_q;
  logic [3:0] min1_q, sec1_q;
  logic       busy_q, done_q;

  logic       accept;
  logic       tx_ready, tx_load;
  logic [7:0] tx_data, char_d;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    char_d = ASCII_LF;
    case (char_idx_q)
      3'd1:    char_d = digit_to_ascii(min1_q);
      3'd2:    char_d = ASCII_COLON;
      3'd3:    char_d = digit_to_ascii({1'b0, sec2_q});
      3'd4:    char_d = digit_to_ascii(sec1_q);
      3'd5:    char_d = ASCII_CR;
      default: char_d = ASCII_LF;
    endcase
  end

  // The first character is taken straight from the inputs so its start bit follows acceptance.
  assign tx_load = accept || ((state_q == START_BIT) && tx_ready && (char_idx_q != 3'd7));
  assign tx_data = accept ? digit_to_ascii({1'b0, min2}) : char_d;

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (tx_load),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .txd_o  (TxD)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      char_idx_q <= '0;
      min2_q     <= '0;
      min1_q     <= '0;
      sec2_q     <= '0;
      sec1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= START_BIT;
            busy_q     <= 1'b1;
            char_idx_q <= 3'd1;
            min2_q     <= min2;
            min1_q     <= min1;
            sec2_q     <= sec2;
            sec1_q     <= sec1;
          end
        end
        START_BIT: begin
          if (tx_ready) begin
            if (char_idx_q == 3'd7) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              char_idx_q <= char_idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          char_idx_q <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_time_transmitter.sv
// tb/tb_uart_time_transmitter.sv - scoreboard bench decoding TxD against queued expected characters
module tb_uart_time_transmitter;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] min2 = '0, sec2 = '0;
  logic [3:0] min1 = '0, sec1 = '0;
  logic       TxD, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_time_transmitter #(.BAUD_DIV(BD)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .min2 (min2),
    .min1 (min1),
    .sec2 (sec2),
    .sec1 (sec1),
    .TxD  (TxD),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'd0, d});
  endfunction

  task automatic push_expected(input logic [3:0] m2, input logic [3:0] m1,
                               input logic [3:0] s2, input logic [3:0] s1);
    exp_q.push_back(exp_char(m2));
    exp_q.push_back(exp_char(m1));
    exp_q.push_back(8'h3A);
    exp_q.push_back(exp_char(s2));
    exp_q.push_back(exp_char(s1));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Line decoder: each bit window is BD samples that must all agree.
  bit         dec_active = 0;
  int         dec_pos, dec_cyc;
  logic       dec_bit, dec_stable;
  logic [7:0] dec_sh;
  logic [7:0] dec_exp;

  always @(negedge clk) begin
    if (reset) begin
      dec_active = 0;
    end else begin
      if (dec_active) begin
        if (dec_cyc == BD) begin
          check("bitw", {31'd0, dec_stable}, 32'd1);
          if (dec_pos >= 1 && dec_pos <= 8) dec_sh[dec_pos-1] = dec_bit;
          if (dec_pos == 9) begin
            check("stop", {31'd0, dec_bit}, 32'd1);
            dec_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
            check("byte", {24'd0, dec_sh}, {24'd0, dec_exp});
          end
          dec_pos++;
          if (dec_pos == 10) begin
            dec_active = 0;
          end else begin
            dec_bit    = TxD;
            dec_cyc    = 1;
            dec_stable = 1;
          end
        end else begin
          if (TxD !== dec_bit) dec_stable = 0;
          dec_cyc++;
        end
      end
      if (!dec_active) begin
        if (busy) check("gap", {31'd0, TxD}, 32'd0);
        else      check("idle", {31'd0, TxD}, 32'd1);
        if (TxD === 1'b0) begin
          dec_active = 1;
          dec_pos    = 0;
          dec_bit    = 1'b0;
          dec_cyc    = 1;
          dec_stable = 1;
        end
      end
    end
  end

  // mode: 0 plain, 1 extra starts mid-report, 2 inputs change mid-report,
  //       3 start during the done cycle, 4 release reset together with start
  task automatic run_report(input logic [3:0] m2, input logic [3:0] m1,
                            input logic [3:0] s2, input logic [3:0] s1, input int mode);
    int   lat;
    logic busy_ok, idle_ok;
    lat     = 0;
    busy_ok = 1'b1;
    idle_ok = 1'b1;
    push_expected(m2, m1, s2, s1);
    @(negedge clk);
    min2  = m2[2:0];
    min1  = m1;
    sec2  = s2[2:0];
    sec1  = s1;
    start = 1'b1;
    if (mode == 4) reset = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 80 * BD; n++) begin
      @(negedge clk);
      start = (mode == 1) && (n == 5 || n == 300);
      if (mode == 2 && n == 100) begin
        min2 = 3'd5; min1 = 4'd9; sec2 = 3'd5; sec1 = 4'd9;
      end
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (mode == 3) start = 1'b1;
    check("latency", lat, 70 * BD + 1);
    check("busy_cont", {31'd0, busy_ok}, 32'd1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) idle_ok = 1'b0;
    end
    check("idle_after", {31'd0, idle_ok}, 32'd1);
    check("drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_txd", {31'd0, TxD}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_report(4'd1, 4'd2, 4'd3, 4'd4, 0);
    run_report(4'd1, 4'd2, 4'd3, 4'd4, 1);
    run_report(4'd1, 4'd2, 4'd3, 4'd4, 2);
    run_report(4'd0, 4'd12, 4'd0, 4'd0, 3);
    run_report(4'd7, 4'd9, 4'd5, 4'd10, 0);

    // Abort during data bit 3 of the second character ('2': that bit is 0 on the line).
    push_expected(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    min2 = 3'd1; min1 = 4'd2; sec2 = 3'd3; sec1 = 4'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (229) @(posedge clk);
    #2;
    check("pre_rst_txd", {31'd0, TxD}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort_txd", {31'd0, TxD}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sent", exp_q.size(), 32'd6);
    exp_q.delete();
    repeat (3) @(posedge clk);
    run_report(4'd1, 4'd2, 4'd3, 4'd4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
